// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: captures trap state from the verifier's packed word,
// redirects the PC to the handler, returns on uret, and serves csrrw/csrrwi.
module trap_csr_unit #(
  parameter logic [15:0] HANDLER_ADDR = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception,
  input  logic [31:0] excep_info,
  input  logic        uret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        irq,
  output logic [31:0] csr_rdata,
  output logic [31:0] csr_info,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        stall
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

  state_t      state;
  state_t      state_next;
  logic        take_trap;
  logic        take_ret;
  logic        do_write;

  logic [15:0] mstatus;
  logic [15:0] mip;
  logic [15:0] mepc;
  logic [15:0] mtvec;
  logic [6:0]  mcause;
  logic        cause_type;

  // Only the low 16 bits and bit 31 (mcause cause_type) of a write carry state.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, csr_wdata[30:16]};

  // Handshake: exception/uret/csr_we are single-cycle requests sampled at the edge;
  // only IDLE accepts them, with priority exception > uret > csr_we.
  always_comb begin
    state_next = state;
    take_trap  = 1'b0;
    take_ret   = 1'b0;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (exception) begin
          state_next = TRAP;
          take_trap  = 1'b1;
        end else if (uret) begin
          state_next = RET;
          take_ret   = 1'b1;
        end else if (csr_we) begin
          do_write   = 1'b1;
        end
      end
      TRAP:    state_next = IDLE;
      RET:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {16'h0, mstatus};
      ADDR_MTVEC:   csr_rdata = {16'h0, mtvec};
      ADDR_MEPC:    csr_rdata = {16'h0, mepc};
      ADDR_MCAUSE:  csr_rdata = {cause_type, 24'h0, mcause};
      ADDR_MIP:     csr_rdata = {16'h0, mip};
      default:      csr_rdata = 32'h0;
    endcase
  end

  assign csr_info = {mip, mstatus};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mstatus     <= 16'h0;
      mip         <= 16'h0;
      mepc        <= 16'h0;
      mtvec       <= HANDLER_ADDR;
      mcause      <= 7'h0;
      cause_type  <= 1'b0;
      redirect    <= 1'b0;
      stall       <= 1'b0;
      redirect_pc <= 16'h0;
    end else begin
      state       <= state_next;
      redirect    <= take_trap | take_ret;
      stall       <= take_trap | take_ret;
      redirect_pc <= take_trap ? mtvec : (take_ret ? mepc : 16'h0);
      mip[0]      <= irq;

      if (take_trap) begin
        mepc       <= excep_info[15:0];
        cause_type <= excep_info[31];
        mcause     <= excep_info[30:24];
        mstatus    <= {8'h00, excep_info[23:16]};
      end

      if (take_ret) mstatus <= 16'h0001;

      if (do_write) begin
        case (csr_addr)
          ADDR_MSTATUS: mstatus <= csr_wdata[15:0];
          ADDR_MTVEC:   mtvec   <= {csr_wdata[15:2], 2'b00};
          ADDR_MEPC:    mepc    <= csr_wdata[15:0];
          ADDR_MCAUSE: begin
            cause_type <= csr_wdata[31];
            mcause     <= csr_wdata[6:0];
          end
          ADDR_MIP:     mip[15:1] <= csr_wdata[15:1];
          default: ;
        endcase
      end
    end
  end

endmodule
